// File: rtl/viterbi_ber_checker_if.sv
// rtl/viterbi_ber_checker_if.sv - stream and result bundle for the Viterbi BER checker
`timescale 1ns/1ps

interface viterbi_ber_checker_if #(
  parameter int CNT_W = 16
) ();

  // Measurement control and the two bit streams being realigned.
  logic             start_i;
  logic             ref_valid_i;
  logic             ref_bit_i;
  logic             dec_bit_i;

  // Registered measurement results.
  logic             busy_o;
  logic             done_o;
  logic [CNT_W-1:0] bit_cnt_o;
  logic [CNT_W-1:0] err_cnt_o;
  logic             first_err_vld_o;
  logic [CNT_W-1:0] first_err_idx_o;
  logic [CNT_W-1:0] burst_max_o;

  // Stimulus side: drives the streams, observes results.
  modport master (
    output start_i,
    output ref_valid_i,
    output ref_bit_i,
    output dec_bit_i,
    input  busy_o,
    input  done_o,
    input  bit_cnt_o,
    input  err_cnt_o,
    input  first_err_vld_o,
    input  first_err_idx_o,
    input  burst_max_o
  );

  // Checker side.
  modport slave (
    input  start_i,
    input  ref_valid_i,
    input  ref_bit_i,
    input  dec_bit_i,
    output busy_o,
    output done_o,
    output bit_cnt_o,
    output err_cnt_o,
    output first_err_vld_o,
    output first_err_idx_o,
    output burst_max_o
  );

endinterface

// File: rtl/viterbi_ber_checker.sv
// rtl/viterbi_ber_checker.sv - realigns encoder input to decoder output and grades bit errors over a window
`timescale 1ns/1ps

module viterbi_ber_checker #(
  parameter int DEC_LATENCY = 16,
  parameter int WINDOW      = 256,
  parameter int CNT_W       = 16
) (
  input logic                  clk,
  input logic                  rst,
  viterbi_ber_checker_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

  state_t state_q, state_d;

  // Delay line: index 0 is the head, index DEC_LATENCY-1 is the tap.
  logic [DEC_LATENCY-1:0] dl_vld_q, dl_vld_d;
  logic [DEC_LATENCY-1:0] dl_bit_q, dl_bit_d;

  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] burst_max_q, burst_max_d;
  logic [CNT_W-1:0] first_idx_q, first_idx_d;
  logic             first_vld_q, first_vld_d;

  logic             tap_vld;
  logic             tap_bit;
  logic             cmp_en;
  logic             cmp_err;
  logic [CNT_W-1:0] run_inc;

  assign tap_vld = dl_vld_q[DEC_LATENCY-1];
  assign tap_bit = dl_bit_q[DEC_LATENCY-1];

  // A restart discards whatever compare would have happened on the same edge.
  assign cmp_en  = tap_vld && (state_q == S_COUNT) && !bus.start_i;
  assign cmp_err = tap_bit ^ bus.dec_bit_i;
  assign run_inc = run_q + CNT_ONE;

  // Delay line shift; start invalidates everything in flight except the new head entry.
  always_comb begin
    dl_vld_d    = '0;
    dl_bit_d    = '0;
    dl_vld_d[0] = bus.ref_valid_i & ((state_q != S_IDLE) | bus.start_i);
    dl_bit_d[0] = bus.ref_bit_i;
    for (int i = 1; i < DEC_LATENCY; i++) begin
      dl_vld_d[i] = dl_vld_q[i-1] & ~bus.start_i;
      dl_bit_d[i] = dl_bit_q[i-1];
    end
  end

  // Measurement state: next state from start pulses and the window-closing compare.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) state_d = S_COUNT;
      end
      S_COUNT: begin
        if (bus.start_i) begin
          state_d = S_COUNT;
        end else if (cmp_en && (bit_cnt_q == CNT_LAST)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.start_i) state_d = S_COUNT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Result counters: cleared by start, advanced only on a graded compare.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    err_cnt_d   = err_cnt_q;
    run_d       = run_q;
    burst_max_d = burst_max_q;
    first_idx_d = first_idx_q;
    first_vld_d = first_vld_q;
    if (bus.start_i) begin
      bit_cnt_d   = '0;
      err_cnt_d   = '0;
      run_d       = '0;
      burst_max_d = '0;
      first_idx_d = '0;
      first_vld_d = 1'b0;
    end else if (cmp_en) begin
      bit_cnt_d = bit_cnt_q + CNT_ONE;
      if (cmp_err) begin
        err_cnt_d   = err_cnt_q + CNT_ONE;
        run_d       = run_inc;
        burst_max_d = (run_inc > burst_max_q) ? run_inc : burst_max_q;
        if (!first_vld_q) begin
          first_idx_d = bit_cnt_q;
          first_vld_d = 1'b1;
        end
      end else begin
        run_d = '0;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Delay line registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dl_vld_q <= '0;
      dl_bit_q <= '0;
    end else begin
      dl_vld_q <= dl_vld_d;
      dl_bit_q <= dl_bit_d;
    end
  end

  // Result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_q   <= '0;
      err_cnt_q   <= '0;
      run_q       <= '0;
      burst_max_q <= '0;
      first_idx_q <= '0;
      first_vld_q <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      err_cnt_q   <= err_cnt_d;
      run_q       <= run_d;
      burst_max_q <= burst_max_d;
      first_idx_q <= first_idx_d;
      first_vld_q <= first_vld_d;
    end
  end

  assign bus.busy_o          = (state_q == S_COUNT);
  assign bus.done_o          = (state_q == S_DONE);
  assign bus.bit_cnt_o       = bit_cnt_q;
  assign bus.err_cnt_o       = err_cnt_q;
  assign bus.first_err_vld_o = first_vld_q;
  assign bus.first_err_idx_o = first_idx_q;
  assign bus.burst_max_o     = burst_max_q;

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// tb/tb_viterbi_ber_checker.sv - scoreboard bench for the Viterbi BER checker
`timescale 1ns/1ps

module tb_viterbi_ber_checker;

  localparam int L  = 16;
  localparam int W  = 256;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  viterbi_ber_checker_if #(.CNT_W(CW)) bus ();

  viterbi_ber_checker #(
    .DEC_LATENCY(L),
    .WINDOW     (W),
    .CNT_W      (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    int id;
    int bits;
    int errs;
    int fvld;
    int fidx;
    int burst;
    int done_edge;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit refv    [0:1023];
  bit refb    [0:1023];
  bit errmask [0:511];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input int id, input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL t%0d %s actual=%0d required=%0d", id, name, act, req);
    end
  endtask

  task automatic clear_mask();
    for (int i = 0; i < 512; i++) errmask[i] = 1'b0;
  endtask

  task automatic set_idle();
    bus.start_i     = 1'b0;
    bus.ref_valid_i = 1'b0;
    bus.ref_bit_i   = 1'b0;
    bus.dec_bit_i   = 1'b0;
  endtask

  // Drives ncyc cycles starting with a start pulse. dec_bit_i is the reference
  // delayed by L, flipped where errmask marks the compare index; bits entered
  // before a restart are deliberately corrupted so counting them would show.
  task automatic run_stream(input int ncyc, input bit toggle, input int restart_at,
                            input bit do_push, input exp_t e);
    int cmp_idx;
    int gf;
    bit v;
    bit b;
    bit d;
    exp_t ex;
    cmp_idx = 0;
    gf      = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (restart_at >= 0 && c == restart_at + 1) begin
        check(e.id, "restart_bit_cnt", int'(bus.bit_cnt_o), 0);
        check(e.id, "restart_err_cnt", int'(bus.err_cnt_o), 0);
        check(e.id, "restart_busy", int'(bus.busy_o), 1);
      end
      if (c == 0 && do_push) begin
        ex           = e;
        ex.done_edge = cyc + 1 + e.done_edge;
        exp_q.push_back(ex);
      end
      bus.start_i = (c == 0) || (c == restart_at);
      if (c == restart_at) begin
        gf      = c;
        cmp_idx = 0;
      end
      v = toggle ? (c % 2 == 0) : 1'b1;
      b = 1'($urandom_range(0, 1));
      refv[c] = v;
      refb[c] = b;
      bus.ref_valid_i = v;
      bus.ref_bit_i   = b;
      if (c >= L && refv[c-L]) begin
        if (c - L >= gf) begin
          d = refb[c-L] ^ ((cmp_idx < 512) ? errmask[cmp_idx] : 1'b0);
          cmp_idx++;
        end else begin
          d = ~refb[c-L];
        end
      end else begin
        d = 1'($urandom_range(0, 1));
      end
      bus.dec_bit_i = d;
    end
  endtask

  // Monitor: every rising done_o is graded against the oldest pending expectation.
  initial begin : monitor
    bit   prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done_o && !prev) begin
        if (exp_q.size() == 0) begin
          check(0, "unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check(e.id, "bit_cnt", int'(bus.bit_cnt_o), e.bits);
          check(e.id, "err_cnt", int'(bus.err_cnt_o), e.errs);
          check(e.id, "first_err_vld", int'(bus.first_err_vld_o), e.fvld);
          check(e.id, "first_err_idx", int'(bus.first_err_idx_o), e.fidx);
          check(e.id, "burst_max", int'(bus.burst_max_o), e.burst);
          check(e.id, "busy_at_done", int'(bus.busy_o), 0);
          check(e.id, "done_edge", cyc, e.done_edge);
        end
      end
      prev = bus.done_o;
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog timeout pending=%0d", exp_q.size());
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    exp_t e;
    set_idle();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check(0, "rst_busy", int'(bus.busy_o), 0);
    check(0, "rst_done", int'(bus.done_o), 0);
    check(0, "rst_bit_cnt", int'(bus.bit_cnt_o), 0);
    check(0, "rst_err_cnt", int'(bus.err_cnt_o), 0);
    check(0, "rst_first_vld", int'(bus.first_err_vld_o), 0);
    check(0, "rst_first_idx", int'(bus.first_err_idx_o), 0);
    check(0, "rst_burst", int'(bus.burst_max_o), 0);
    rst = 1'b1;
    @(negedge clk);

    // 1: clean stream, 256th compare lands L+255 edges after start.
    clear_mask();
    e = '{id:1, bits:256, errs:0, fvld:0, fidx:0, burst:0, done_edge:L + 255};
    run_stream(300, 1'b0, -1, 1'b1, e);

    // 2: errors at 10,11,12 and 100, restarted from DONE.
    clear_mask();
    errmask[10] = 1'b1; errmask[11] = 1'b1; errmask[12] = 1'b1; errmask[100] = 1'b1;
    e = '{id:2, bits:256, errs:4, fvld:1, fidx:10, burst:3, done_edge:L + 255};
    run_stream(300, 1'b0, -1, 1'b1, e);

    // 7: errors on the very first and very last compares.
    clear_mask();
    errmask[0] = 1'b1; errmask[1] = 1'b1; errmask[128] = 1'b1;
    errmask[254] = 1'b1; errmask[255] = 1'b1;
    e = '{id:7, bits:256, errs:5, fvld:1, fidx:0, burst:2, done_edge:L + 255};
    run_stream(280, 1'b0, -1, 1'b1, e);

    // 3: alternating valid, errors on compares 5 and 6 across an invalid gap.
    clear_mask();
    errmask[5] = 1'b1; errmask[6] = 1'b1;
    e = '{id:3, bits:256, errs:2, fvld:1, fidx:5, burst:2, done_edge:L + 2 * 255};
    run_stream(540, 1'b1, -1, 1'b1, e);

    // 4: restart on compare 200; new window's first compare is L edges after the restart.
    clear_mask();
    errmask[50] = 1'b1;
    e = '{id:4, bits:256, errs:1, fvld:1, fidx:50, burst:1, done_edge:216 + L + 255};
    run_stream(500, 1'b0, 216, 1'b1, e);

    // 6: start on the same edge as the 256th compare.
    clear_mask();
    e = '{id:6, bits:0, errs:0, fvld:0, fidx:0, burst:0, done_edge:0};
    run_stream(L + 256, 1'b0, L + 255, 1'b0, e);
    @(negedge clk);
    set_idle();
    check(6, "coincident_done", int'(bus.done_o), 0);
    check(6, "coincident_busy", int'(bus.busy_o), 1);
    check(6, "coincident_bit_cnt", int'(bus.bit_cnt_o), 0);
    repeat (L + 4) @(negedge clk);
    check(6, "post_bit_cnt", int'(bus.bit_cnt_o), 1);
    check(6, "post_done", int'(bus.done_o), 0);

    // 5: async reset mid-window with seven errors counted.
    clear_mask();
    errmask[3] = 1'b1; errmask[4] = 1'b1; errmask[20] = 1'b1; errmask[21] = 1'b1;
    errmask[22] = 1'b1; errmask[50] = 1'b1; errmask[70] = 1'b1;
    e = '{id:5, bits:0, errs:0, fvld:0, fidx:0, burst:0, done_edge:0};
    run_stream(100, 1'b0, -1, 1'b0, e);
    @(negedge clk);
    set_idle();
    check(5, "pre_rst_err_cnt", int'(bus.err_cnt_o), 7);
    check(5, "pre_rst_bit_cnt", int'(bus.bit_cnt_o), 100 - L);
    check(5, "pre_rst_burst", int'(bus.burst_max_o), 3);
    check(5, "pre_rst_first_idx", int'(bus.first_err_idx_o), 3);
    #2;
    rst = 1'b0;
    #1;
    check(5, "async_busy", int'(bus.busy_o), 0);
    check(5, "async_err_cnt", int'(bus.err_cnt_o), 0);
    check(5, "async_bit_cnt", int'(bus.bit_cnt_o), 0);
    check(5, "async_burst", int'(bus.burst_max_o), 0);
    check(5, "async_first_vld", int'(bus.first_err_vld_o), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      bus.ref_valid_i = 1'b1;
      bus.ref_bit_i   = 1'($urandom_range(0, 1));
      bus.dec_bit_i   = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    set_idle();
    check(5, "idle_bit_cnt", int'(bus.bit_cnt_o), 0);
    check(5, "idle_err_cnt", int'(bus.err_cnt_o), 0);
    check(5, "idle_busy", int'(bus.busy_o), 0);
    check(5, "idle_done", int'(bus.done_o), 0);

    repeat (4) @(negedge clk);
    check(0, "pending_results", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
